uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 deserializer with a small receive FIFO.
// Ports: clk, rst_n (sync, active-high), rx_i serial in;
//   rx_data_o/rx_valid_o/rx_ready_i FIFO head handshake;
//   frame_err_o, overrun_o one-cycle pulses; busy_o, fifo_count_o status.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           armed_q, armed_d;
  logic [1:0]     sync_q;
  logic           frame_err_q;
  logic           overrun_q;
  logic           rx_s;
  logic           push;
  logic           ferr;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           full;
  logic           pop;
  logic           wr_en;
  logic           ovr;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  // armed_q blocks a new start after a framing error until the
  // line has been seen high, so a held break is not re-received.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    armed_d = armed_q;
    push    = 1'b0;
    ferr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            ferr    = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign rx_valid_o = (count_q != '0);
  assign pop        = rx_valid_o & rx_ready_i;
  // A same-cycle pop frees a slot, so a full FIFO still accepts.
  assign wr_en      = push & (~full | pop);
  assign ovr        = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_q + CW'(wr_en) - CW'(pop);
      frame_err_q <= ferr;
      overrun_q   <= ovr;
    end
  end

  assign rx_data_o    = mem_q[rd_ptr_q];
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: random and directed 8N1 frames,
// scoreboard queue of expected bytes checked by a pop monitor.
module tb_uart_rx;

  localparam int C   = 16;
  localparam int D   = 4;
  localparam int LAT = 2 + 1 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;
  logic [2:0] fifo_count_o;

  int         n_chk = 0;
  int         n_fail = 0;
  int         frm_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] exp_q[$];
  bit         rand_on;

  uart_rx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; expected byte is queued when a push is predicted.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input bit push_exp);
    if (push_exp) exp_q.push_back(b);
    rx_i = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      if (i == 4) begin
        tick(C / 2);
        check("busy_mid_frame", busy_o, 1);
        tick(C - C / 2);
      end else begin
        tick(C);
      end
    end
    rx_i = stop_ok;
    tick(C);
    rx_i = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    rx_ready_i = 1'b1;
    while ((exp_q.size() != 0 || rx_valid_o) && k < 100) begin
      tick(1);
      k++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", rx_valid_o, 0);
    rx_ready_i = 1'b0;
  endtask

  // Monitor: every accepted head byte is compared with the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_unexpected: got %02h required none",
                   rx_data_o);
        end else begin
          check("pop_data", rx_data_o, exp_q.pop_front());
        end
      end
      if (frame_err_o) frm_cnt++;
      if (overrun_o) ovr_cnt++;
      if (frame_err_o || overrun_o) begin
        check("flag_exclusive", frame_err_o & overrun_o, 0);
      end
    end
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout required finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    int         lat;
    int         f0;
    int         o0;
    int         exp_frm;
    logic [7:0] b;
    bit         ok;

    rst_n      = 1'b1;
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;
    tick(5);
    check("rst_valid", rx_valid_o, 0);
    check("rst_data", rx_data_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_count", fifo_count_o, 0);
    rst_n = 1'b0;
    tick(3);
    check("post_rst_valid", rx_valid_o, 0);
    check("post_rst_busy", busy_o, 0);

    // Single byte, consumer stalled: exact push latency.
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        while (!rx_valid_o && lat < 400) begin
          tick(1);
          lat++;
        end
        check("push_latency", lat, LAT);
        check("a5_data", rx_data_o, 8'hA5);
        check("a5_count", fifo_count_o, 1);
      end
    join
    check("a5_no_ferr", frm_cnt, 0);
    check("a5_no_ovr", ovr_cnt, 0);
    drain();

    // Back-to-back frames with consumer always ready.
    rx_ready_i = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    tick(20);
    check("b2b_popped", exp_q.size(), 0);
    check("b2b_idle", busy_o, 0);
    check("b2b_count", fifo_count_o, 0);
    rx_ready_i = 1'b0;

    // Fill past capacity: fifth byte dropped with one overrun.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, i <= D);
    end
    check("full_count", fifo_count_o, D);
    check("overrun_once", ovr_cnt, 1);
    check("full_head", rx_data_o, 8'h01);

    // Push and pop in the same cycle while full.
    fork
      send_frame(8'h06, 1'b1, 1'b1);
      begin
        tick(LAT - 1);
        rx_ready_i = 1'b1;
        tick(1);
        rx_ready_i = 1'b0;
      end
    join
    check("full_pp_count", fifo_count_o, D);
    check("full_pp_no_ovr", ovr_cnt, 1);
    drain();

    // Framing error followed by a held break.
    f0 = frm_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_i = 1'b0;
    tick(200);
    check("break_idle", busy_o, 0);
    check("break_count", fifo_count_o, 0);
    rx_i = 1'b1;
    tick(20);
    check("ferr_single", frm_cnt - f0, 1);
    check("ferr_count", fifo_count_o, 0);
    check("ferr_valid", rx_valid_o, 0);

    // Short low glitch on the idle line.
    f0 = frm_cnt;
    rx_i = 1'b0;
    tick(6);
    rx_i = 1'b1;
    tick(200);
    check("glitch_idle", busy_o, 0);
    check("glitch_count", fifo_count_o, 0);
    check("glitch_ferr", frm_cnt - f0, 0);

    // Reset in the middle of a frame with two bytes queued.
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    check("pre_rst_count", fifo_count_o, 2);
    rx_i = 1'b0;
    tick(C);
    rx_i = 1'b1;
    tick(C);
    rx_i = 1'b0;
    tick(C / 2);
    rst_n = 1'b1;
    rx_i  = 1'b1;
    exp_q.delete();
    tick(3);
    rst_n = 1'b0;
    check("midrst_count", fifo_count_o, 0);
    check("midrst_valid", rx_valid_o, 0);
    check("midrst_data", rx_data_o, 0);
    tick(200);
    check("midrst_no_push", fifo_count_o, 0);
    check("midrst_busy", busy_o, 0);
    send_frame(8'h96, 1'b1, 1'b1);
    drain();

    // Random frames, random stop bits, random consumer.
    f0      = frm_cnt;
    o0      = ovr_cnt;
    exp_frm = 0;
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          b  = 8'($urandom);
          ok = ($urandom_range(0, 7) != 0);
          if (!ok) exp_frm++;
          send_frame(b, ok, ok);
          if (!ok) tick(4 + $urandom_range(0, 8));
          else tick($urandom_range(0, 8));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          rx_ready_i = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    drain();
    check("rand_ferr", frm_cnt - f0, exp_frm);
    check("rand_no_ovr", ovr_cnt - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
